// File: rtl/pfd_pkg.sv
// Shared types and limits for the DMS PLL phase-frequency detector.
package pfd_pkg;

    typedef enum logic [1:0] {PFD_IDLE, PFD_UP, PFD_DN, PFD_BOTH} pfd_state_t;

    localparam int PFD_RST_DLY_MAX = 15;
    localparam int PFD_BCNT_W      = $clog2(PFD_RST_DLY_MAX + 1);

endpackage

// File: rtl/dms_pfd_sync_if.sv
// Signal bundle between the loop controller and the PFD.
// err_valid is a one-cycle strobe with no back-pressure: phase_err is new on that cycle and holds until the next strobe.
interface dms_pfd_sync_if #(
    parameter int CNT_W = 8
);
    logic                    d;
    logic                    ref_in;
    logic                    fb_in;
    logic                    up;
    logic                    down;
    logic signed [CNT_W-1:0] phase_err;
    logic                    err_valid;

    modport master (
        output d, ref_in, fb_in,
        input  up, down, phase_err, err_valid
    );

    modport slave (
        input  d, ref_in, fb_in,
        output up, down, phase_err, err_valid
    );
endinterface

// File: rtl/pfd_edge_det.sv
// Rising-edge detector for a sampled clock input.
// PFD_SYNC_EN adds a two-flop synchronizer ahead of the sample flop.
module pfd_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic samp_in;
    logic samp_q;
    logic samp_prev;

`ifdef PFD_SYNC_EN
    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    assign samp_in = sync2;
`else
    assign samp_in = din;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q    <= 1'b0;
            samp_prev <= 1'b0;
        end else begin
            samp_q    <= samp_in;
            samp_prev <= samp_q;
        end
    end

    assign rise = samp_q & ~samp_prev;
endmodule

// File: rtl/dms_pfd_sync.sv
// Clock-sampled tri-state PFD: drives up/down to the charge pump and reports signed pulse width.
// Build option PFD_SYNC_EN inserts input synchronizers (two extra cycles of latency).
module dms_pfd_sync
    import pfd_pkg::*;
#(
    parameter int RST_DLY = 2,   // legal range 1..PFD_RST_DLY_MAX
    parameter int CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    dms_pfd_sync_if.slave  bus,
    output pfd_state_t     dbg_state
);
    localparam logic [PFD_BCNT_W-1:0] BCNT_LAST = PFD_BCNT_W'(RST_DLY - 1);

    logic ref_rise;
    logic fb_rise;
    logic ref_ev;
    logic fb_ev;

    pfd_state_t state;
    pfd_state_t next;

    logic [PFD_BCNT_W-1:0]   bcnt;
    logic [CNT_W-2:0]        cnt;
    logic                    from_up;
    logic                    first_both;
    logic signed [CNT_W-1:0] mag;

    logic                    up_r;
    logic                    dn_r;
    logic                    ev_r;
    logic signed [CNT_W-1:0] err_r;

    pfd_edge_det u_ref_det (.clk(clk), .rst(rst), .din(bus.ref_in), .rise(ref_rise));
    pfd_edge_det u_fb_det  (.clk(clk), .rst(rst), .din(bus.fb_in),  .rise(fb_rise));

    assign ref_ev = ref_rise & bus.d;
    assign fb_ev  = fb_rise & bus.d;

    always_comb begin
        next = state;
        case (state)
            PFD_IDLE: begin
                if (ref_ev && fb_ev) next = PFD_BOTH;
                else if (ref_ev)     next = PFD_UP;
                else if (fb_ev)      next = PFD_DN;
            end
            PFD_UP:   if (fb_ev)  next = PFD_BOTH;
            PFD_DN:   if (ref_ev) next = PFD_BOTH;
            PFD_BOTH: if (bcnt == BCNT_LAST) next = PFD_IDLE;
            default:  next = PFD_IDLE;
        endcase
    end

    // Error is published on the first BOTH cycle, aligned with up=down=1 at the outputs.
    assign first_both = (state == PFD_BOTH) && (bcnt == '0);
    assign mag        = {1'b0, cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PFD_IDLE;
            bcnt    <= '0;
            cnt     <= '0;
            from_up <= 1'b0;
            up_r    <= 1'b0;
            dn_r    <= 1'b0;
            ev_r    <= 1'b0;
            err_r   <= '0;
        end else begin
            state <= next;
            bcnt  <= (state == PFD_BOTH && next == PFD_BOTH) ? bcnt + PFD_BCNT_W'(1) : '0;

            if (state == PFD_UP || state == PFD_DN) begin
                if (cnt != '1) cnt <= cnt + (CNT_W-1)'(1);
                from_up <= (state == PFD_UP);
            end

            up_r <= (state == PFD_UP) || (state == PFD_BOTH);
            dn_r <= (state == PFD_DN) || (state == PFD_BOTH);
            ev_r <= first_both;

            if (first_both) begin
                err_r <= from_up ? mag : -mag;
                cnt   <= '0;
            end
        end
    end

    assign bus.up        = up_r;
    assign bus.down      = dn_r;
    assign bus.err_valid = ev_r;
    assign bus.phase_err = err_r;
    assign dbg_state     = state;
endmodule

// File: tb/tb_dms_pfd_sync.sv
// Bench for dms_pfd_sync: vector table, hand-written corner sequences and a randomized run against a timestamp model.
module tb_dms_pfd_sync;
    import pfd_pkg::*;

    localparam int RST_DLY = 2;
    localparam int CNT_W   = 8;
    localparam int SAT     = 127;
`ifdef PFD_SYNC_EN
    localparam int SDLY = 2;
`else
    localparam int SDLY = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dms_pfd_sync_if #(.CNT_W(CNT_W)) bus();
    pfd_state_t dbg_state;

    dms_pfd_sync #(.RST_DLY(RST_DLY), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // Time-stamp view: who leads and since which edge, and the edge BOTH began.
    logic [7:0] m_rh = '0;
    logic [7:0] m_fh = '0;
    int m_lead   = 0;
    int m_lead_t = 0;
    int m_both_t = -1;
    int m_err    = 0;
    int m_edge   = 0;

    logic e_up = 1'b0, e_dn = 1'b0, e_ev = 1'b0;
    logic signed [31:0] e_err = 0;
    logic o_up, o_dn, o_ev;
    logic signed [31:0] o_err;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, m_edge);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic model_edge(input logic r, input logic f, input logic dd, input logic rs);
        logic rr, fr;
        m_edge++;
        if (rs) begin
            e_up = 0; e_dn = 0; e_ev = 0; e_err = 0;
            m_rh = '0; m_fh = '0; m_lead = 0; m_both_t = -1; m_err = 0;
            return;
        end
        // Outputs visible after this edge reflect the model's position one edge earlier.
        e_up = (m_lead == 1)  || (m_both_t >= 0);
        e_dn = (m_lead == -1) || (m_both_t >= 0);
        e_ev = (m_both_t >= 0) && (m_both_t == m_edge - 1);
        if (e_ev) e_err = m_err;

        rr = m_rh[SDLY] & ~m_rh[SDLY+1] & dd;
        fr = m_fh[SDLY] & ~m_fh[SDLY+1] & dd;
        m_rh = {m_rh[6:0], r};
        m_fh = {m_fh[6:0], f};

        if (m_both_t >= 0) begin
            if (m_edge - m_both_t >= RST_DLY) m_both_t = -1;
        end else if (m_lead == 0) begin
            if (rr && fr) begin m_both_t = m_edge; m_err = 0; end
            else if (rr)  begin m_lead = 1;  m_lead_t = m_edge; end
            else if (fr)  begin m_lead = -1; m_lead_t = m_edge; end
        end else if (m_lead == 1 && fr) begin
            m_both_t = m_edge; m_err = sat(m_edge - m_lead_t); m_lead = 0;
        end else if (m_lead == -1 && rr) begin
            m_both_t = m_edge; m_err = -sat(m_edge - m_lead_t); m_lead = 0;
        end
    endtask

    // ---------------- driver: one clock, model update, output compare ----------------
    task automatic step(input logic r, input logic f, input logic dd, input logic rs);
        @(negedge clk);
        bus.ref_in = r; bus.fb_in = f; bus.d = dd; rst = rs;
        @(posedge clk);
        model_edge(r, f, dd, rs);
        #1;
        o_up = bus.up; o_dn = bus.down; o_ev = bus.err_valid; o_err = bus.phase_err;
        chk("up", {31'd0, o_up}, {31'd0, e_up});
        chk("down", {31'd0, o_dn}, {31'd0, e_dn});
        chk("err_valid", {31'd0, o_ev}, {31'd0, e_ev});
        chk("phase_err", o_err, e_err);
    endtask

    typedef struct {
        int   ref_at;
        int   fb_at;
        logic dd;
        int   up_only;
        int   dn_only;
        int   both;
        int   evs;
        int   err;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n_up, n_dn, n_both, n_ev, len, hits;
        logic signed [31:0] last_err;
        logic r, f, dd, rs;

        bus.d = 1'b1; bus.ref_in = 1'b0; bus.fb_in = 1'b0;

        tbl[0] = '{0,   5,   1'b1, 5,   0, 2, 1, 5};
        tbl[1] = '{3,   0,   1'b1, 0,   3, 2, 1, -3};
        tbl[2] = '{2,   2,   1'b1, 0,   0, 2, 1, 0};
        tbl[3] = '{0,   1,   1'b1, 1,   0, 2, 1, 1};
        tbl[4] = '{0,   200, 1'b1, 200, 0, 2, 1, 127};
        tbl[5] = '{0,   5,   1'b0, 0,   0, 0, 0, 0};
        tbl[6] = '{4,   10,  1'b1, 6,   0, 2, 1, 6};

        // Reset with inputs toggling
        for (int i = 0; i < 3; i++) begin
            step(i[0], ~i[0], 1'b1, 1'b1);
            chk("rst_up", {31'd0, o_up}, 0);
            chk("rst_down", {31'd0, o_dn}, 0);
            chk("rst_ev", {31'd0, o_ev}, 0);
            chk("rst_err", o_err, 0);
        end

        // Table of single-pulse scenarios, each from a fresh reset
        for (int v = 0; v < 7; v++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            n_up = 0; n_dn = 0; n_both = 0; n_ev = 0; last_err = 0;
            len = ((tbl[v].ref_at > tbl[v].fb_at) ? tbl[v].ref_at : tbl[v].fb_at) + 12;
            for (int t = 0; t < len; t++) begin
                step(t >= tbl[v].ref_at, t >= tbl[v].fb_at, tbl[v].dd, 1'b0);
                if (o_up && !o_dn) n_up++;
                if (!o_up && o_dn) n_dn++;
                if (o_up && o_dn)  n_both++;
                if (o_ev) begin n_ev++; last_err = o_err; end
            end
            chk($sformatf("vec%0d_up_cycles", v), n_up, tbl[v].up_only);
            chk($sformatf("vec%0d_dn_cycles", v), n_dn, tbl[v].dn_only);
            chk($sformatf("vec%0d_both_cycles", v), n_both, tbl[v].both);
            chk($sformatf("vec%0d_err_valids", v), n_ev, tbl[v].evs);
            chk($sformatf("vec%0d_phase_err", v), last_err, tbl[v].err);
            for (int t = 0; t < 3; t++) step(1'b0, 1'b0, 1'b1, 1'b0);
        end

        // ref at twice the fb frequency, fb lagging: up holds across the second ref edge
        step(1'b0, 1'b0, 1'b1, 1'b1);
        last_err = 0; n_ev = 0;
        for (int t = 0; t < 76; t++) begin
            step((t % 22) < 11, (t >= 30) && (((t - 30) % 44) < 22), 1'b1, 1'b0);
            if (t == 26) begin
                chk("f2x_up_hold", {31'd0, o_up}, 1);
                chk("f2x_dn_low", {31'd0, o_dn}, 0);
            end
            if (o_ev && n_ev == 0) begin last_err = o_err; n_ev++; end
        end
        chk("f2x_phase_err", last_err, 30);

        // d low suppresses pulses; raising d resumes from the next qualified edge
        step(1'b0, 1'b0, 1'b0, 1'b1);
        hits = 0; last_err = 0; n_ev = 0;
        for (int t = 0; t < 80; t++) begin
            step((t % 10) < 5, ((t + 7) % 10) < 5, t >= 40, 1'b0);
            if (t <= 41 && (o_up || o_dn)) hits++;
            if (o_ev && n_ev == 0) begin last_err = o_err; n_ev++; end
        end
        chk("dlow_quiet", hits, 0);
        chk("dlow_resume_err", last_err, 3);

        // Reset in the middle of an UP pulse: outputs clear and no error strobe follows
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int t = 0; t < 4; t++) step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("midrst_up", {31'd0, o_up}, 0);
        chk("midrst_down", {31'd0, o_dn}, 0);
        n_ev = 0;
        for (int t = 0; t < 8; t++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            if (o_ev) n_ev++;
        end
        chk("midrst_no_ev", n_ev, 0);

        // Randomized traffic against the model
        step(1'b0, 1'b0, 1'b1, 1'b1);
        r = 1'b0; f = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            if ($urandom_range(0, 5) == 0) r = ~r;
            if ($urandom_range(0, 5) == 0) f = ~f;
            dd = ($urandom_range(0, 19) != 0);
            rs = ($urandom_range(0, 299) == 0);
            step(r, f, dd, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
